// File: rtl/au_arbiter_if.sv
// Requester, arithmetic-unit and drain-control signals of au_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface au_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [15:0] req0_x;
    logic [15:0] req1_x;
    logic [7:0]  req0_y;
    logic [7:0]  req1_y;
    logic        req0_mode;
    logic        req1_mode;
    logic [15:0] au_x;
    logic [7:0]  au_y;
    logic        au_mode;
    logic [31:0] au_p;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_p;
    logic        drain_req;
    logic        drain_done;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_x, req1_x, req0_y, req1_y,
        input  req0_mode, req1_mode, au_p, drain_req,
        output req0_ready, req1_ready, au_x, au_y, au_mode,
        output rsp0_valid, rsp1_valid, rsp_p, drain_done, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_x, req1_x, req0_y, req1_y,
        output req0_mode, req1_mode, au_p, drain_req,
        input  req0_ready, req1_ready, au_x, au_y, au_mode,
        input  rsp0_valid, rsp1_valid, rsp_p, drain_done, busy
    );
endinterface

// File: rtl/au_arbiter.sv
// Two-requester arbiter for a shared pipelined multiplier; results return after LATENCY+1 edges.
// Define AU_ARBITER_FIXED_PRI_EN for fixed req0 priority instead of round-robin.
module au_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    au_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_t;

    state_t           r_state;
    logic [LATENCY:0] r_vld;
    logic [LATENCY:0] r_tag;
    logic [15:0]      r_au_x;
    logic [7:0]       r_au_y;
    logic             r_au_mode;
    logic [31:0]      r_rsp_p;
    logic             r_rsp0_vld;
    logic             r_rsp1_vld;

    logic             w_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_xfer;
    logic             w_busy;

    // A drain request blocks grants in the very cycle it is raised.
    assign w_accept = (r_state == RUN) && !bus.drain_req;

`ifdef AU_ARBITER_FIXED_PRI_EN
    assign w_grant0 = w_accept && bus.req0_valid;
    assign w_grant1 = w_accept && bus.req1_valid && !bus.req0_valid;
`else
    logic r_last;  // 1: req1 was granted most recently, so req0 is favoured

    assign w_grant0 = w_accept && bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_grant1 = w_accept && bus.req1_valid && (!bus.req0_valid || !r_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_grant0) begin
            r_last <= 1'b0;
        end else if (w_grant1) begin
            r_last <= 1'b1;
        end
    end
`endif

    assign w_xfer = w_grant0 || w_grant1;
    assign w_busy = |r_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_au_x    <= 16'h0;
            r_au_y    <= 8'h0;
            r_au_mode <= 1'b0;
        end else if (w_grant0) begin
            r_au_x    <= bus.req0_x;
            r_au_y    <= bus.req0_y;
            r_au_mode <= bus.req0_mode;
        end else if (w_grant1) begin
            r_au_x    <= bus.req1_x;
            r_au_y    <= bus.req1_y;
            r_au_mode <= bus.req1_mode;
        end else begin
            r_au_x    <= 16'h0;
            r_au_y    <= 8'h0;
            r_au_mode <= 1'b0;
        end
    end

    // Tag travels alongside the multiplier pipeline; the last stage picks up au_p.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld      <= '0;
            r_tag      <= '0;
            r_rsp_p    <= 32'h0;
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
        end else begin
            r_vld      <= {r_vld[LATENCY-1:0], w_xfer};
            r_tag      <= {r_tag[LATENCY-1:0], w_grant1};
            r_rsp0_vld <= r_vld[LATENCY] && !r_tag[LATENCY];
            r_rsp1_vld <= r_vld[LATENCY] &&  r_tag[LATENCY];
            if (r_vld[LATENCY]) begin
                r_rsp_p <= bus.au_p;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.drain_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!bus.drain_req) begin
                        r_state <= RUN;
                    end else if (!w_busy) begin
                        r_state <= DRAINED;
                    end
                end
                DRAINED: begin
                    if (!bus.drain_req) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.au_x       = r_au_x;
    assign bus.au_y       = r_au_y;
    assign bus.au_mode    = r_au_mode;
    assign bus.rsp_p      = r_rsp_p;
    assign bus.rsp0_valid = r_rsp0_vld;
    assign bus.rsp1_valid = r_rsp1_vld;
    assign bus.busy       = w_busy;
    assign bus.drain_done = (r_state == DRAINED);

endmodule

// File: tb/tb_au_arbiter.sv
// Scoreboard bench for au_arbiter with a multiply model of the arithmetic unit.
module tb_au_arbiter;
    localparam int LAT = 2;
`ifdef AU_ARBITER_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    au_arbiter_if bus();

    au_arbiter #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Arithmetic unit: au_p = au_x*au_y delayed LAT cycles
    logic [31:0] p_pipe [LAT];
    always @(posedge clk) begin
        p_pipe[0] <= {16'h0, bus.au_x} * {24'h0, bus.au_y};
        for (int i = 1; i < LAT; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign bus.au_p = p_pipe[LAT-1];

    typedef struct {
        bit          tag;
        logic [31:0] p;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] last_p = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per strobe and checks value, owner and timing
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rsp0_valid && bus.rsp1_valid) begin
                checks++;
                errors++;
                $display("FAIL rsp_both: got both strobes high at cycle %0d expected at most one", cyc);
            end else if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got strobe p=%h at cycle %0d expected none", bus.rsp_p, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk1("rsp_tag", bus.rsp1_valid, mon_e.tag);
                    chk("rsp_p", bus.rsp_p, mon_e.p);
                    chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                    last_p = bus.rsp_p;
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing: got no strobe by cycle %0d expected p=%h at cycle %0d", cyc, mon_e.p, mon_e.cyc);
            end
        end
    end

    task automatic cycle(input int v0, input int x0, input int y0, input int m0,
                         input int v1, input int x1, input int y1, input int m1,
                         input int drn, input int er0, input int er1);
        bus.req0_valid = 1'(v0);
        bus.req0_x     = 16'(x0);
        bus.req0_y     = 8'(y0);
        bus.req0_mode  = 1'(m0);
        bus.req1_valid = 1'(v1);
        bus.req1_x     = 16'(x1);
        bus.req1_y     = 8'(y1);
        bus.req1_mode  = 1'(m1);
        bus.drain_req  = 1'(drn);
        @(negedge clk);
        chk1("req0_ready", bus.req0_ready, 1'(er0));
        chk1("req1_ready", bus.req1_ready, 1'(er1));
        if (v0 != 0 && er0 != 0)
            sb.push_back('{1'b0, {16'h0, bus.req0_x} * {24'h0, bus.req0_y}, cyc + LAT + 2});
        if (v1 != 0 && er1 != 0)
            sb.push_back('{1'b1, {16'h0, bus.req1_x} * {24'h0, bus.req1_y}, cyc + LAT + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.drain_req  = 1'b0;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_au_x"}, {16'h0, bus.au_x}, 32'h0);
        chk({tag, "_au_y"}, {24'h0, bus.au_y}, 32'h0);
        chk1({tag, "_au_mode"}, bus.au_mode, 1'b0);
        chk({tag, "_rsp_p"}, bus.rsp_p, 32'h0);
        chk1({tag, "_rsp0_valid"}, bus.rsp0_valid, 1'b0);
        chk1({tag, "_rsp1_valid"}, bus.rsp1_valid, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_drain_done"}, bus.drain_done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test expected finish before 100000 time units");
        $fatal(1);
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_x = 16'h0; bus.req0_y = 8'h0; bus.req0_mode = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_x = 16'h0; bus.req1_y = 8'h0; bus.req1_mode = 1'b0;
        bus.drain_req  = 1'b0;
        do_reset();
        chk_all_zero("reset");

        // Single request: 3*5
        cycle(1, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        chk1("single_busy", bus.busy, 1'b1);
        idle(6);
        chk("single_p", last_p, 32'd15);

        // Both valid: alternating grants, results 2,20,4,22
        do_reset();
        cycle(1, 1, 2, 0, 1, 10, 2, 0, 0, 1, 0);
        cycle(1, 2, 2, 0, 1, 10, 2, 0, 0, 0, 1);
        cycle(1, 2, 2, 0, 1, 11, 2, 0, 0, 1, 0);
        cycle(1, 3, 2, 0, 1, 11, 2, 0, 0, 0, 1);
        idle(6);
        chk("rr_last_p", last_p, 32'd22);

        // Full-width operands and mode pass-through
        cycle(1, 16'hFFFF, 8'hFF, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("wide_au_x", {16'h0, bus.au_x}, 32'h0000_FFFF);
        chk("wide_au_y", {24'h0, bus.au_y}, 32'h0000_00FF);
        chk1("wide_au_mode", bus.au_mode, 1'b1);
        idle(5);
        chk("wide_p", last_p, 32'h00FE_FF01);

        // Drain while req1 streams 100*3
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 0, 0, 1);
        chk1("drain_busy1", bus.busy, 1'b1);
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 0, 0, 1);
        chk1("drain_busy2", bus.busy, 1'b1);
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 1, 0, 0);
        chk1("drain_busy3", bus.busy, 1'b1);
        chk1("drain_done3", bus.drain_done, 1'b0);
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 1, 0, 0);
        chk1("drain_busy4", bus.busy, 1'b1);
        chk1("drain_done4", bus.drain_done, 1'b0);
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 1, 0, 0);
        chk1("drain_busy5", bus.busy, 1'b0);
        chk1("drain_done5", bus.drain_done, 1'b0);
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 1, 0, 0);
        chk1("drain_done6", bus.drain_done, 1'b1);
        chk("drain_p", last_p, 32'd300);
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 0, 0, 0);
        chk1("drain_done7", bus.drain_done, 1'b0);
        cycle(0, 0, 0, 0, 1, 100, 3, 0, 0, 0, 1);
        idle(6);

        // Contention for 3 cycles, then req0 withdraws
        cycle(1, 2, 2, 0, 1, 3, 3, 0, 0, 1, 0);
        cycle(1, 2, 2, 0, 1, 3, 3, 0, 0, FIXED ? 1 : 0, FIXED ? 0 : 1);
        cycle(1, 2, 2, 0, 1, 3, 3, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 1);
        idle(6);
        chk("pri_last_p", last_p, 32'd9);

        // Reset one cycle after a transfer discards it
        cycle(1, 7, 7, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk_all_zero("rst_assert");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        reset = 1'b0;
        idle(8);
        chk_all_zero("rst_after");

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
